// File: rtl/sng_pkg.sv
// Shared definitions for the stochastic-number decoder: default widths,
// FSM state encoding and the count-width helper.
package sng_pkg;

    localparam int QUANT_DEF     = 8;
    localparam int BITSTREAM_DEF = 64;

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    // A frame of t bits can hold 0..t ones, so one extra bit over log2(t).
    function automatic int count_w(input int t);
        return $clog2(t) + 1;
    endfunction

endpackage

// File: rtl/sng_popcount.sv
// Purely combinational ones counter for one beat of stochastic bits.
module sng_popcount #(
    parameter int LANES = 8
) (
    input  logic [LANES-1:0]       bits,
    output logic [$clog2(LANES):0] ones
);

    localparam int PC_W = $clog2(LANES) + 1;

    always_comb begin
        ones = '0;
        for (int i = 0; i < LANES; i++) begin
            ones = ones + PC_W'(bits[i]);
        end
    end

endmodule

// File: rtl/sng_decoder.sv
// Accumulates the ones of a BITSTREAM-bit stochastic frame delivered LANES bits
// per beat and converts the count to a rounded, saturated signed value.
module sng_decoder
    import sng_pkg::*;
#(
    parameter int BITSTREAM = BITSTREAM_DEF,
    parameter int QUANT     = QUANT_DEF,
    parameter int LANES     = 8
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic                      iClear,
    input  logic                      iValid,
    output logic                      oReady,
    input  logic [LANES-1:0]          iBits,
    output logic                      oValid,
    input  logic                      iReady,
    output logic [QUANT-1:0]          oData,
    output logic [$clog2(BITSTREAM):0] oCount,
    output logic                      oSat
);

    localparam int LOG_T  = $clog2(BITSTREAM);
    localparam int CNT_W  = count_w(BITSTREAM);
    localparam int PC_W   = $clog2(LANES) + 1;
    localparam int BEATS  = BITSTREAM / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DEC_W  = QUANT + LOG_T + 2;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    // Returns {sat, data}. Division by the frame length is a right shift with
    // half-LSB added beforehand for round-half-up.
    function automatic logic [QUANT:0] decode(input logic [CNT_W-1:0] cnt);
        logic signed [DEC_W-1:0] u;
        logic signed [DEC_W-1:0] q;
        logic signed [DEC_W-1:0] qmax;
        u    = (DEC_W'(cnt) << QUANT) + DEC_W'(BITSTREAM / 2);
        u    = u >>> LOG_T;
        q    = u - (DEC_W'(1) << (QUANT - 1));
        qmax = (DEC_W'(1) << (QUANT - 1)) - DEC_W'(1);
        if (q > qmax) begin
            return {1'b1, qmax[QUANT-1:0]};
        end
        return {1'b0, q[QUANT-1:0]};
    endfunction

    state_t             state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [QUANT-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;

    logic [PC_W-1:0]    beat_ones;
    logic [CNT_W-1:0]   frame_sum;
    logic [QUANT:0]     dec;
    logic               beat_fire;
    logic               res_fire;

    sng_popcount #(
        .LANES(LANES)
    ) u_popcount (
        .bits(iBits),
        .ones(beat_ones)
    );

    assign oReady    = (state_q == S_OUT) ? iReady : 1'b1;
    assign oValid    = (state_q == S_OUT);
    assign oData     = data_q;
    assign oCount    = count_q;
    assign oSat      = sat_q;

    assign beat_fire = iValid && oReady;
    assign res_fire  = oValid && iReady;
    assign frame_sum = acc_q + CNT_W'(beat_ones);
    assign dec       = decode(frame_sum);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        acc_d   = acc_q;
        data_d  = data_q;
        count_d = count_q;
        sat_d   = sat_q;
        if (iClear) begin
            state_d = S_ACC;
            beat_d  = '0;
            acc_d   = '0;
        end else begin
            if (res_fire) begin
                state_d = S_ACC;
            end
            // A beat can land in the same cycle the previous result retires.
            if (beat_fire) begin
                if (beat_q == LAST_BEAT) begin
                    beat_d  = '0;
                    acc_d   = '0;
                    count_d = frame_sum;
                    data_d  = dec[QUANT-1:0];
                    sat_d   = dec[QUANT];
                    state_d = S_OUT;
                end else begin
                    beat_d = beat_q + BEAT_W'(1);
                    acc_d  = frame_sum;
                end
            end
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_ACC;
            beat_q  <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            acc_q   <= acc_d;
            data_q  <= data_d;
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

endmodule
